// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder
//   Pipelined carry-lookahead adder/subtractor with a valid/ready handshake.
//   The operands are split into NGRP = WIDTH/GROUP blocks of GROUP bits. Stage k
//   resolves block k with a GROUP-bit lookahead carry network. It uses the block
//   carry registered by stage k-1, or the effective carry-in for stage 0. Operand
//   blocks above k travel with the beat, and finished sum bits travel forward.
//   The last stage register is the output register.
//
//   Optional feature: define CLA_PIPE_SAT_EN to add the 'sat' port. With sat=1, a
//   signed overflow clamps sum to the signed max or min. c_out and overflow still
//   report the unsaturated result.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset; discards every in-flight beat
//   in_valid   operand beat valid
//   in_ready   beat can be accepted (= !out_valid || out_ready)
//   a, b       operands (WIDTH)
//   c_in       carry-in for add; ignored for subtract
//   op         0: a + b + c_in, 1: a - b
//   sat        saturate on signed overflow (CLA_PIPE_SAT_EN only)
//   out_valid  result valid
//   out_ready  downstream accepts result
//   sum        result (WIDTH)
//   c_out      carry out of MSB (subtract: 1 = no borrow)
//   overflow   signed overflow (carry into MSB xor carry out of MSB)
module cla_pipe_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             op,
`ifdef CLA_PIPE_SAT_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    localparam int unsigned NGRP = WIDTH / GROUP;

    if ((WIDTH % GROUP) != 0 || NGRP < 1) begin : g_bad_cfg
        $error("cla_pipe_adder: WIDTH must be a non-zero multiple of GROUP");
    end

    // One enable for every stage: the whole pipe holds while the output is stalled.
    logic adv;

    assign in_ready = !out_valid || out_ready;
    assign adv      = in_ready;

    for (genvar k = 0; k < NGRP; k++) begin : stg
        localparam int unsigned LO = k * GROUP;
        localparam int unsigned HI = LO + GROUP;

        logic [WIDTH-1:LO] opa;      // operand A blocks k..NGRP-1
        logic [WIDTH-1:LO] opb;      // effective operand B blocks k..NGRP-1
        logic              cin;
        logic              v_in;
        logic [HI-1:0]     sum_mod;  // all sum bits finished after this stage
        logic [HI-1:0]     sum_d;
`ifdef CLA_PIPE_SAT_EN
        logic              sat_in;
`endif

        logic [GROUP-1:0]  g;
        logic [GROUP-1:0]  p;
        logic [GROUP-1:0]  s;
        logic [GROUP:0]    c;
        logic              pp;

        logic              v_q;
        logic              c_q;
        logic [HI-1:0]     sum_q;

        if (k == 0) begin : head
            assign opa     = a;
            assign opb     = op ? ~b : b;
            assign cin     = op | c_in;
            assign v_in    = in_valid;
            assign sum_mod = s;
`ifdef CLA_PIPE_SAT_EN
            assign sat_in  = sat;
`endif
        end else begin : body
            assign opa     = stg[k-1].fwd.opa_q;
            assign opb     = stg[k-1].fwd.opb_q;
            assign cin     = stg[k-1].c_q;
            assign v_in    = stg[k-1].v_q;
            assign sum_mod = {s, stg[k-1].sum_q};
`ifdef CLA_PIPE_SAT_EN
            assign sat_in  = stg[k-1].fwd.sat_q;
`endif
        end

        // Lookahead carries in sum-of-products form:
        // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin
        always_comb begin
            g    = opa[HI-1:LO] & opb[HI-1:LO];
            p    = opa[HI-1:LO] ^ opb[HI-1:LO];
            c    = '0;
            pp   = 1'b1;
            c[0] = cin;
            for (int unsigned i = 0; i < GROUP; i++) begin
                pp = 1'b1;
                for (int unsigned m = 0; m <= i; m++) begin
                    c[i+1] = c[i+1] | (g[i-m] & pp);
                    pp     = pp & p[i-m];
                end
                c[i+1] = c[i+1] | (cin & pp);
            end
            s = p ^ c[GROUP-1:0];
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                v_q   <= 1'b0;
                c_q   <= 1'b0;
                sum_q <= '0;
            end else if (adv) begin
                v_q   <= v_in;
                c_q   <= c[GROUP];
                sum_q <= sum_d;
            end
        end

        if (k < NGRP - 1) begin : fwd
            logic [WIDTH-1:HI] opa_q;
            logic [WIDTH-1:HI] opb_q;
`ifdef CLA_PIPE_SAT_EN
            logic              sat_q;
`endif

            assign sum_d = sum_mod;

            always_ff @(posedge clk) begin
                if (rst) begin
                    opa_q <= '0;
                    opb_q <= '0;
`ifdef CLA_PIPE_SAT_EN
                    sat_q <= 1'b0;
`endif
                end else if (adv) begin
                    opa_q <= opa[WIDTH-1:HI];
                    opb_q <= opb[WIDTH-1:HI];
`ifdef CLA_PIPE_SAT_EN
                    sat_q <= sat_in;
`endif
                end
            end
        end else begin : last
            logic ovf_d;
            logic ovf_q;

            assign ovf_d = c[GROUP] ^ c[GROUP-1];

`ifdef CLA_PIPE_SAT_EN
            // On overflow the true result has the sign of A.
            // Clamp it to the signed extreme with that sign.
            assign sum_d = (sat_in && ovf_d)
                         ? {opa[WIDTH-1], {(WIDTH-1){~opa[WIDTH-1]}}}
                         : sum_mod;
`else
            assign sum_d = sum_mod;
`endif

            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (adv) begin
                    ovf_q <= ovf_d;
                end
            end
        end
    end

    assign out_valid = stg[NGRP-1].v_q;
    assign sum       = stg[NGRP-1].sum_q;
    assign c_out     = stg[NGRP-1].c_q;
    assign overflow  = stg[NGRP-1].last.ovf_q;

endmodule
